apb_regfile_slave: RTL and testbench

//  Parametrised APB3 register-file slave: DEPTH words of DATA_W bits behind one APB port,

---
 rtl/apb_regfile_slave.sv | 141 ++++++++++++++
 tb/tb_apb_regfile_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave: DEPTH words of DATA_W bits, programmable wait states, PSLVERR on illegal addresses.
// Optional byte-lane strobes: define APB_REGFILE_PSTRB_EN to add the Pstrb port and masked writes.
`timescale 1ns/1ps

module apb_regfile_slave #(
  parameter int                 DATA_W      = 32,
  parameter int                 ADDR_W      = 8,
  parameter int                 DEPTH       = 16,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                  PCLK,
  input  logic                  Presetn,
  input  logic [ADDR_W-1:0]     Paddr,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [DATA_W-1:0]     Pwdata,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_W/8-1:0]   Pstrb,
`endif
  output logic                  Pready,
  output logic [DATA_W-1:0]     Prdata,
  output logic                  Pslverr
);

  localparam int         BYTES    = DATA_W / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                access;
  logic                ready;
  logic                aligned;
  logic                legal;
  logic                wr_en;
  logic [ADDR_W:0]     idx_ext;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   wr_mask;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign access = Psel & Penable;

  // Address decode: one extra bit so DEPTH == 2**(ADDR_W-OFF_W) still compares correctly.
  assign idx_ext = {1'b0, Paddr} >> OFF_W;
  assign idx     = idx_ext[IDX_W-1:0];

  generate
    if (OFF_W > 0) begin : g_align
      assign aligned = (Paddr[OFF_W-1:0] == '0);
    end else begin : g_no_align
      assign aligned = 1'b1;
    end
  endgenerate

  assign legal = aligned && (idx_ext < (ADDR_W+1)'(DEPTH));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          if (WAIT_CYCLES == 0) begin
            ready = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!access) begin
          // Master abandoned the access phase: drop it without completing.
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == WAIT_LIM) begin
          ready     = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge Presetn) begin
    if (!Presetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef APB_REGFILE_PSTRB_EN
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      wr_mask[8*b +: 8] = {8{Pstrb[b]}};
    end
  end
`else
  assign wr_mask = '1;
`endif

  assign wr_en = ready & Pwrite & legal;

  // NOTE: the storage is reset word by word because every word must read RESET_VAL after reset.
  always_ff @(posedge PCLK or negedge Presetn) begin
    if (!Presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      mem[idx] <= (mem[idx] & ~wr_mask) | (Pwdata & wr_mask);
    end
  end

  assign Pready  = ready;
  assign Pslverr = ready & ~legal;
  assign Prdata  = (ready & ~Pwrite & legal) ? mem[idx] : '0;

`ifndef SYNTHESIS
  a_err_with_ready : assert property (@(posedge PCLK) disable iff (!Presetn) Pslverr |-> Pready);
  a_cnt_bounded    : assert property (@(posedge PCLK) disable iff (!Presetn) cnt <= WAIT_LIM);
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: two instances (0 and 3 wait states) on separate APB buses.
// Stimulus pushes expected completions; a negedge monitor pops and compares on every Pready.
`timescale 1ns/1ps

module tb_apb_regfile_slave;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'hA5A5_5A5A;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  paddr   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];
`ifdef APB_REGFILE_PSTRB_EN
  logic [3:0]  pstrb   [2];
  logic [3:0]  cur_strb = 4'hF;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   wcnt[2];

  always #5 clk = ~clk;

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0), .RESET_VAL(RV0)
  ) u_dut0 (
    .PCLK(clk), .Presetn(rst_n), .Paddr(paddr[0]), .Psel(psel[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Pwdata(pwdata[0]),
`ifdef APB_REGFILE_PSTRB_EN
    .Pstrb(pstrb[0]),
`endif
    .Pready(pready[0]), .Prdata(prdata[0]), .Pslverr(pslverr[0])
  );

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3), .RESET_VAL(RV1)
  ) u_dut1 (
    .PCLK(clk), .Presetn(rst_n), .Paddr(paddr[1]), .Psel(psel[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Pwdata(pwdata[1]),
`ifdef APB_REGFILE_PSTRB_EN
    .Pstrb(pstrb[1]),
`endif
    .Pready(pready[1]), .Prdata(prdata[1]), .Pslverr(pslverr[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Monitor: compares every completed transfer against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt[0] = 0;
      wcnt[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (psel[d] && penable[d]) begin
          if (pready[d]) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_ready", 64'(exp_q.size()), 64'd1);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("sb_dut", 64'(d), 64'(e.dut));
              check("sb_prdata", prdata[d], e.data);
              check("sb_pslverr", pslverr[d], e.err);
              check("sb_wait_states", 64'(wcnt[d]), 64'(e.waits));
            end
            wcnt[d] = 0;
          end else begin
            wcnt[d]++;
          end
        end else begin
          check("idle_outputs", {pready[d], pslverr[d], prdata[d]}, '0);
          wcnt[d] = 0;
        end
      end
    end
  end

  // Complete transfer; on return the bus is idle and the next call may start SETUP at once.
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err);
    bit seen;
    exp_q.push_back('{d, exp_data, exp_err, waits_of(d)});
    paddr[d]   = addr;
    pwrite[d]  = wr;
    pwdata[d]  = wdata;
`ifdef APB_REGFILE_PSTRB_EN
    pstrb[d]   = cur_strb;
`endif
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = pready[d];
    end
    check("ready_timeout", seen, 1);
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [7:0] addr, input logic [31:0] data, input logic err);
    apb_xfer(d, 1'b1, addr, data, 32'h0, err);
  endtask

  task automatic rd(input int d, input logic [7:0] addr, input logic [31:0] data, input logic err);
    apb_xfer(d, 1'b0, addr, 32'h0, data, err);
  endtask

  // Starts an access and holds it for n ACCESS cycles without completion; bus left asserted.
  task automatic apb_partial(input int d, input logic w, input logic [7:0] addr,
                             input logic [31:0] data, input int n);
    paddr[d]   = addr;
    pwrite[d]  = w;
    pwdata[d]  = data;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("wait_ready_low", pready[d], 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string name);
    for (int d = 0; d < 2; d++) begin
      check(name, {pready[d], pslverr[d], prdata[d]}, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      paddr[d] = '0; psel[d] = 0; penable[d] = 0; pwrite[d] = 0; pwdata[d] = '0;
`ifdef APB_REGFILE_PSTRB_EN
      pstrb[d] = '0;
`endif
    end
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset_held_outputs");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Zero wait states, back-to-back write then read.
    wr(0, 8'h3C, 32'hDEAD_BEEF, 0);
    rd(0, 8'h3C, 32'hDEAD_BEEF, 0);
    wr(0, 8'h00, 32'h1122_3344, 0);
    wr(0, 8'h20, 32'hCAFE_F00D, 0);
    rd(0, 8'h00, 32'h1122_3344, 0);
    rd(0, 8'h20, 32'hCAFE_F00D, 0);

    // Illegal addresses: out of range and misaligned.
    wr(0, 8'h40, 32'hFFFF_FFFF, 1);
    wr(0, 8'h05, 32'hFFFF_FFFF, 1);
    rd(0, 8'h40, 32'h0, 1);
    rd(0, 8'hFE, 32'h0, 1);
    rd(0, 8'h00, 32'h1122_3344, 0);
    rd(0, 8'h04, RV0, 0);
    rd(0, 8'h3C, 32'hDEAD_BEEF, 0);

    // Unselected Penable toggling and lingering SETUP must not write.
    paddr[0] = 8'h00; pwrite[0] = 1'b1; pwdata[0] = 32'h0BAD_0BAD;
    repeat (4) begin
      @(posedge clk); #1 penable[0] = ~penable[0];
    end
    penable[0] = 1'b0;
    psel[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 psel[0] = 1'b0;
    rd(0, 8'h00, 32'h1122_3344, 0);

    // Byte strobes.
`ifdef APB_REGFILE_PSTRB_EN
    cur_strb = 4'b0101;
    wr(0, 8'h00, 32'hAABB_CCDD, 0);
    cur_strb = 4'hF;
    rd(0, 8'h00, 32'h11BB_33DD, 0);
    cur_strb = 4'b0000;
    wr(0, 8'h00, 32'hFFFF_FFFF, 0);
    cur_strb = 4'hF;
    rd(0, 8'h00, 32'h11BB_33DD, 0);
`else
    wr(0, 8'h00, 32'hAABB_CCDD, 0);
    rd(0, 8'h00, 32'hAABB_CCDD, 0);
`endif

    // Three wait states, abort, error.
    rd(1, 8'h00, RV1, 0);
    wr(1, 8'h08, 32'h1234_5678, 0);
    rd(1, 8'h08, 32'h1234_5678, 0);
    apb_partial(1, 1'b1, 8'h08, 32'hFFFF_FFFF, 2);
    penable[1] = 1'b0;
    @(posedge clk); #1 psel[1] = 1'b0;
    rd(1, 8'h08, 32'h1234_5678, 0);
    wr(1, 8'h44, 32'h0, 1);
    rd(1, 8'h0A, 32'h0, 1);

    // Reset in the cycle where Pready would rise.
    apb_partial(1, 1'b1, 8'h0C, 32'h0F0F_0F0F, 3);
    rst_n = 1'b0;
    #1 check("reset_kills_ready", pready[1], 0);
    psel[1] = 1'b0;
    penable[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("mid_reset_outputs");
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      rd(0, 8'(i * 4), RV0, 0);
      rd(1, 8'(i * 4), RV1, 0);
    end

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
